// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: buffers writeback requests, drains one per
// cycle into WE3/A3/WD3, and forwards pending values to the read ports.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          drain_en,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_hit1,
  output logic          q_hit2,
  output logic [DW-1:0] q_data1,
  output logic [DW-1:0] q_data2,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic push;
  logic pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  // x0 writes complete the handshake but never occupy a slot
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign rf_we    = drain_en && !empty;
  assign pop      = rf_we;
  assign rf_addr  = addr_q[head_q];
  assign rf_wd    = data_q[head_q];
  assign count    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    unique case (1'b1)
      (push && !pop): count_d = count_q + CW'(1);
      (!push && pop): count_d = count_q - CW'(1);
      default:        count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Walk oldest to newest so the last match (closest to tail) wins
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [PW-1:0] idx;
    lookup = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (a != '0) && (addr_q[idx] == a))
        lookup = {1'b1, data_q[idx]};
    end
  endfunction

  assign {q_hit1, q_data1} = lookup(q_addr1);
  assign {q_hit2, q_data2} = lookup(q_addr2);

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed table-driven bench for rf_writeback_queue plus hand-written
// sequences for overflow hold and asynchronous reset.
module tb_rf_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_hit1, q_hit2;
  logic [31:0] q_data1, q_data2;
  logic [5:0]  count;
  logic        full, empty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_writeback_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2),
    .q_data1(q_data1), .q_data2(q_data2),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        dr;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        rdy;
    logic        we;
    logic        chk_rf;
    logic [4:0]  ra;
    logic [31:0] rwd;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic v, input logic [4:0] a, input logic [31:0] d,
    input logic dr, input logic [4:0] q1, input logic [4:0] q2,
    input logic rdy, input logic we,
    input logic chk_rf, input logic [4:0] ra, input logic [31:0] rwd,
    input logic h1, input logic [31:0] d1,
    input logic h2, input logic [31:0] d2,
    input logic [5:0] cnt);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.dr = dr; r.q1 = q1; r.q2 = q2;
    r.rdy = rdy; r.we = we; r.chk_rf = chk_rf; r.ra = ra; r.rwd = rwd;
    r.h1 = h1; r.d1 = d1; r.h2 = h2; r.d2 = d2; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    in_valid = t.v;
    in_addr  = t.a;
    in_data  = t.d;
    drain_en = t.dr;
    q_addr1  = t.q1;
    q_addr2  = t.q2;
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    drive(t);
    #1;
    chk("in_ready", idx, 32'(in_ready), 32'(t.rdy));
    chk("rf_we", idx, 32'(rf_we), 32'(t.we));
    chk("count", idx, 32'(count), 32'(t.cnt));
    chk("full", idx, 32'(full), 32'(t.cnt == 6'd4));
    chk("empty", idx, 32'(empty), 32'(t.cnt == 6'd0));
    chk("q_hit1", idx, 32'(q_hit1), 32'(t.h1));
    chk("q_data1", idx, q_data1, t.d1);
    chk("q_hit2", idx, 32'(q_hit2), 32'(t.h2));
    chk("q_data2", idx, q_data2, t.d2);
    if (t.chk_rf) begin
      chk("rf_addr", idx, 32'(rf_addr), 32'(t.ra));
      chk("rf_wd", idx, rf_wd, t.rwd);
    end
  endtask

  initial begin
    // single push then drain
    tbl.push_back(mk(0,0,0,         1,5,0, 1,0, 0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(1,5,32'hDEADBEEF,1,5,0, 1,0, 0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0,0,0,         1,5,0, 1,1, 1,5,32'hDEADBEEF,
                     1,32'hDEADBEEF,0,0, 1));
    tbl.push_back(mk(0,0,0,         1,5,0, 1,0, 0,0,0, 0,0,0,0, 0));
    // fill to full, fifth push refused and held
    tbl.push_back(mk(1,1,32'h101,0,0,0, 1,0, 0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(1,2,32'h102,0,0,0, 1,0, 1,1,32'h101, 0,0,0,0, 1));
    tbl.push_back(mk(1,3,32'h103,0,0,0, 1,0, 1,1,32'h101, 0,0,0,0, 2));
    tbl.push_back(mk(1,4,32'h104,0,0,0, 1,0, 1,1,32'h101, 0,0,0,0, 3));
    tbl.push_back(mk(1,5,32'h105,0,5,0, 0,0, 1,1,32'h101, 0,0,0,0, 4));
    tbl.push_back(mk(1,5,32'h105,0,5,0, 0,0, 1,1,32'h101, 0,0,0,0, 4));
    tbl.push_back(mk(0,0,0,1,0,0, 0,1, 1,1,32'h101, 0,0,0,0, 4));
    tbl.push_back(mk(0,0,0,1,0,0, 1,1, 1,2,32'h102, 0,0,0,0, 3));
    tbl.push_back(mk(0,0,0,1,0,0, 1,1, 1,3,32'h103, 0,0,0,0, 2));
    tbl.push_back(mk(0,0,0,1,0,0, 1,1, 1,4,32'h104, 0,0,0,0, 1));
    tbl.push_back(mk(0,0,0,1,0,0, 1,0, 0,0,0, 0,0,0,0, 0));
    // forwarding priority
    tbl.push_back(mk(1,7,32'h11,0,7,3, 1,0, 0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(1,3,32'h22,0,7,3, 1,0, 1,7,32'h11,
                     1,32'h11,0,0, 1));
    tbl.push_back(mk(1,7,32'h33,0,7,3, 1,0, 1,7,32'h11,
                     1,32'h11,1,32'h22, 2));
    tbl.push_back(mk(0,0,0,0,7,3, 1,0, 1,7,32'h11,
                     1,32'h33,1,32'h22, 3));
    tbl.push_back(mk(0,0,0,0,9,3, 1,0, 1,7,32'h11,
                     0,0,1,32'h22, 3));
    tbl.push_back(mk(0,0,0,1,7,3, 1,1, 1,7,32'h11,
                     1,32'h33,1,32'h22, 3));
    tbl.push_back(mk(0,0,0,1,7,3, 1,1, 1,3,32'h22,
                     1,32'h33,1,32'h22, 2));
    tbl.push_back(mk(0,0,0,1,7,3, 1,1, 1,7,32'h33,
                     1,32'h33,0,0, 1));
    tbl.push_back(mk(0,0,0,1,7,3, 1,0, 0,0,0, 0,0,0,0, 0));
    // x0 discard
    tbl.push_back(mk(1,0,32'hFFFFFFFF,1,0,0, 1,0, 0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0,0,0,1,0,0, 1,0, 0,0,0, 0,0,0,0, 0));
    // streaming push+pop across pointer wrap
    for (int k = 1; k <= 10; k++) begin
      if (k == 1)
        tbl.push_back(mk(1,5'(k),32'h1000 + 32'(k),1,10,0,
                         1,0, 0,0,0, 0,0,0,0, 0));
      else
        tbl.push_back(mk(1,5'(k),32'h1000 + 32'(k),1,10,0,
                         1,1, 1,5'(k-1),32'h1000 + 32'(k-1),
                         0,0,0,0, 1));
    end
    tbl.push_back(mk(0,0,0,1,10,0, 1,1, 1,10,32'h100A,
                     1,32'h100A,0,0, 1));
    tbl.push_back(mk(0,0,0,1,10,0, 1,0, 0,0,0, 0,0,0,0, 0));

    reset = 1'b0;
    drive(tbl[0]);
    #2;
    chk("rst_count", -1, 32'(count), 0);
    chk("rst_empty", -1, 32'(empty), 1);
    chk("rst_full", -1, 32'(full), 0);
    chk("rst_ready", -1, 32'(in_ready), 1);
    chk("rst_we", -1, 32'(rf_we), 0);
    chk("rst_hit1", -1, 32'(q_hit1), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // async reset with three entries pending and drain enabled
    apply(mk(1,1,32'hA1,0,2,3, 1,0, 0,0,0, 0,0,0,0, 0), 100);
    apply(mk(1,2,32'hA2,0,2,3, 1,0, 1,1,32'hA1, 0,0,0,0, 1), 101);
    apply(mk(1,3,32'hA3,0,2,3, 1,0, 1,1,32'hA1,
             1,32'hA2,0,0, 2), 102);
    apply(mk(0,0,0,1,2,3, 1,1, 1,1,32'hA1,
             1,32'hA2,1,32'hA3, 3), 103);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_we", 104, 32'(rf_we), 0);
    chk("arst_empty", 104, 32'(empty), 1);
    chk("arst_count", 104, 32'(count), 0);
    chk("arst_hit1", 104, 32'(q_hit1), 0);
    chk("arst_hit2", 104, 32'(q_hit2), 0);
    chk("arst_data1", 104, q_data1, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) apply(tbl[i], 200 + i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
